sdram_frame_arbiter: RTL and testbench

SDRAM_FRAME_ARBITER -- requirements
Module: sdram_frame_arbiter

---
 rtl/sdram_frame_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_sdram_frame_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_frame_arbiter.sv
// sdram_frame_arbiter
//   Arbitrates one SDRAM controller between a camera write path and a VGA read path.
//   Bursts of BURST_LEN words walk a FRAME_WORDS-word frame per path. Each path
//   latches a frame-done flag at the end of its frame. The flag and the address clear
//   only through that path's load pulse or through reset. When both paths want the
//   controller, the path that was not granted last is served.
//
// Ports
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   sdram_init_done            controller ready level; no request is issued while low
//   wr_bank / rd_bank          bank selects, sampled on entry to the request state
//   wr_load / rd_load          one-cycle frame restart pulses
//   wfifo_usedw / rfifo_usedw  camera write FIFO / VGA read FIFO fill levels
//   sdram_ack / sdram_done     controller accepted request / burst finished (pulses)
//   sys_wr_req / sys_rd_req    burst request levels, held until sdram_ack
//   sys_addr                   {bank, word address}, constant for the whole burst
//   frame_write_done / frame_read_done  whole frame transferred on that path
module sdram_frame_arbiter #(
  parameter int unsigned BURST_LEN   = 256,
  parameter int unsigned FRAME_WORDS = 307200,
  parameter int unsigned RFIFO_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sdram_init_done,
  input  logic [1:0]  wr_bank,
  input  logic [1:0]  rd_bank,
  input  logic        wr_load,
  input  logic        rd_load,
  input  logic [10:0] wfifo_usedw,
  input  logic [10:0] rfifo_usedw,
  input  logic        sdram_ack,
  input  logic        sdram_done,
  output logic        sys_wr_req,
  output logic        sys_rd_req,
  output logic [21:0] sys_addr,
  output logic        frame_write_done,
  output logic        frame_read_done
);

  typedef enum logic [2:0] {StIdle, StWrReq, StWrWait, StRdReq, StRdWait} state_e;

  localparam logic        GrantWr   = 1'b0;
  localparam logic        GrantRd   = 1'b1;
  localparam logic [20:0] BurstStep = 21'(BURST_LEN);
  localparam logic [20:0] FrameEnd  = 21'(FRAME_WORDS);

  state_e      state_q, state_d;
  logic [21:0] addr_q, addr_d;
  logic [19:0] wr_addr_q, wr_addr_d;
  logic [19:0] rd_addr_q, rd_addr_d;
  logic        wr_done_q, wr_done_d;
  logic        rd_done_q, rd_done_d;
  logic        wr_pend_q, wr_pend_d;
  logic        rd_pend_q, rd_pend_d;
  logic        last_grant_q, last_grant_d;

  logic        wr_elig, rd_elig;
  logic        wr_busy, rd_busy;
  logic [20:0] wr_adv, rd_adv;

  // A load pulse in the same cycle also blocks entry, so a new burst never starts from an
  // address that is being cleared on that very edge.
  assign wr_elig = (32'(wfifo_usedw) >= BURST_LEN) && !wr_done_q && !wr_pend_q && !wr_load;
  assign rd_elig = (32'(rfifo_usedw) <= (RFIFO_DEPTH - BURST_LEN)) && !rd_done_q &&
                   !rd_pend_q && !rd_load;

  assign wr_busy = (state_q == StWrReq) || (state_q == StWrWait);
  assign rd_busy = (state_q == StRdReq) || (state_q == StRdWait);

  // One extra bit so the end-of-frame compare works even when FRAME_WORDS == 2^20.
  assign wr_adv = {1'b0, wr_addr_q} + BurstStep;
  assign rd_adv = {1'b0, rd_addr_q} + BurstStep;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    wr_done_d    = wr_done_q;
    rd_done_d    = rd_done_q;
    wr_pend_d    = wr_pend_q;
    rd_pend_d    = rd_pend_q;
    last_grant_d = last_grant_q;

    // Loads on an idle path act at once; on a busy path they wait for the burst to end.
    if (wr_load) begin
      if (wr_busy) begin
        wr_pend_d = 1'b1;
      end else begin
        wr_addr_d = '0;
        wr_done_d = 1'b0;
      end
    end
    if (rd_load) begin
      if (rd_busy) begin
        rd_pend_d = 1'b1;
      end else begin
        rd_addr_d = '0;
        rd_done_d = 1'b0;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (sdram_init_done) begin
          if (wr_elig && (!rd_elig || (last_grant_q == GrantRd))) begin
            state_d = StWrReq;
            addr_d  = {wr_bank, wr_addr_q};
          end else if (rd_elig) begin
            state_d = StRdReq;
            addr_d  = {rd_bank, rd_addr_q};
          end
        end
      end
      StWrReq: begin
        if (sdram_ack) state_d = StWrWait;
      end
      StWrWait: begin
        if (sdram_done) begin
          state_d      = StIdle;
          last_grant_d = GrantWr;
          // A pending or coincident load wins over both the advance and the frame wrap.
          if (wr_pend_q || wr_load) begin
            wr_addr_d = '0;
            wr_done_d = 1'b0;
            wr_pend_d = 1'b0;
          end else if (wr_adv == FrameEnd) begin
            wr_addr_d = '0;
            wr_done_d = 1'b1;
          end else begin
            wr_addr_d = wr_adv[19:0];
          end
        end
      end
      StRdReq: begin
        if (sdram_ack) state_d = StRdWait;
      end
      StRdWait: begin
        if (sdram_done) begin
          state_d      = StIdle;
          last_grant_d = GrantRd;
          if (rd_pend_q || rd_load) begin
            rd_addr_d = '0;
            rd_done_d = 1'b0;
            rd_pend_d = 1'b0;
          end else if (rd_adv == FrameEnd) begin
            rd_addr_d = '0;
            rd_done_d = 1'b1;
          end else begin
            rd_addr_d = rd_adv[19:0];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      wr_done_q    <= 1'b0;
      rd_done_q    <= 1'b0;
      wr_pend_q    <= 1'b0;
      rd_pend_q    <= 1'b0;
      last_grant_q <= GrantRd;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      wr_done_q    <= wr_done_d;
      rd_done_q    <= rd_done_d;
      wr_pend_q    <= wr_pend_d;
      rd_pend_q    <= rd_pend_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Requests are decoded from the registered state, so they are glitch-free and mutually
  // exclusive by construction.
  assign sys_wr_req       = (state_q == StWrReq);
  assign sys_rd_req       = (state_q == StRdReq);
  assign sys_addr         = addr_q;
  assign frame_write_done = wr_done_q;
  assign frame_read_done  = rd_done_q;

endmodule

// File: tb/tb_sdram_frame_arbiter.sv
// Bench for sdram_frame_arbiter. A controller model answers every request with ack and
// done pulses after programmable delays. Stimulus pushes the expected {path, sys_addr}
// of each request into a queue; a monitor pops and compares on each request rising edge.
module tb_sdram_frame_arbiter;

  typedef struct packed {
    logic        wr;
    logic [21:0] addr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        sdram_init_done;
  logic [1:0]  wr_bank, rd_bank;
  logic        wr_load, rd_load;
  logic [10:0] wfifo_usedw, rfifo_usedw;
  logic        sdram_ack, sdram_done;
  logic        sys_wr_req, sys_rd_req;
  logic [21:0] sys_addr;
  logic        frame_write_done, frame_read_done;

  int vectors = 0;
  int fails   = 0;

  exp_t exp_q[$];

  // FIFO levels follow per-path burst budgets: a path stays eligible until it has been
  // acked wr_limit / rd_limit times in total.
  int          wr_limit = 0, rd_limit = 0;
  int          wr_ack_cnt = 0, rd_ack_cnt = 0, done_cnt = 0;
  logic [10:0] rd_level = 11'd0;
  int          ack_dly = 2, done_dly = 3;
  logic        abort_expected = 1'b0;

  assign wfifo_usedw = (wr_ack_cnt < wr_limit) ? 11'd256 : 11'd0;
  assign rfifo_usedw = (rd_ack_cnt < rd_limit) ? rd_level : 11'd1000;

  sdram_frame_arbiter #(
    .BURST_LEN  (256),
    .FRAME_WORDS(307200),
    .RFIFO_DEPTH(1024)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sdram_init_done (sdram_init_done),
    .wr_bank         (wr_bank),
    .rd_bank         (rd_bank),
    .wr_load         (wr_load),
    .rd_load         (rd_load),
    .wfifo_usedw     (wfifo_usedw),
    .rfifo_usedw     (rfifo_usedw),
    .sdram_ack       (sdram_ack),
    .sdram_done      (sdram_done),
    .sys_wr_req      (sys_wr_req),
    .sys_rd_req      (sys_rd_req),
    .sys_addr        (sys_addr),
    .frame_write_done(frame_write_done),
    .frame_read_done (frame_read_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller model
  logic        r_is_wr;
  logic [21:0] r_addr;
  initial begin
    sdram_ack  = 1'b0;
    sdram_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && (sys_wr_req || sys_rd_req)) begin
        r_is_wr = sys_wr_req;
        r_addr  = sys_addr;
        repeat (ack_dly - 1) @(negedge clk);
        vectors++;
        if (!(r_is_wr ? sys_wr_req : sys_rd_req)) begin
          fails++;
          $display("FAIL req_before_ack: req=0 required 1");
        end
        sdram_ack = 1'b1;
        if (r_is_wr) wr_ack_cnt++;
        else rd_ack_cnt++;
        @(negedge clk);
        sdram_ack = 1'b0;
        vectors++;
        if (sys_wr_req || sys_rd_req) begin
          fails++;
          $display("FAIL req_after_ack: wr=%0b rd=%0b required 0 0", sys_wr_req, sys_rd_req);
        end
        repeat (done_dly - 1) @(negedge clk);
        if (!abort_expected) begin
          vectors++;
          if (sys_addr !== r_addr) begin
            fails++;
            $display("FAIL addr_held: sys_addr=%06h required %06h", sys_addr, r_addr);
          end
        end
        sdram_done = 1'b1;
        @(negedge clk);
        sdram_done = 1'b0;
        done_cnt++;
      end
    end
  end

  // Monitor: compares every new request against the scoreboard
  logic prev_wr = 1'b0, prev_rd = 1'b0;
  exp_t got;
  initial begin
    forever begin
      @(negedge clk);
      if (sys_wr_req || sys_rd_req) begin
        vectors++;
        if (sys_wr_req && sys_rd_req) begin
          fails++;
          $display("FAIL req_overlap: wr=1 rd=1 required at most one");
        end
      end
      if ((sys_wr_req && !prev_wr) || (sys_rd_req && !prev_rd)) begin
        vectors++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_req: wr=%0b addr=%06h required no request",
                   sys_wr_req, sys_addr);
        end else begin
          got = exp_q.pop_front();
          if (got.wr !== sys_wr_req || got.addr !== sys_addr) begin
            fails++;
            $display("FAIL req_order: wr=%0b addr=%06h required wr=%0b addr=%06h",
                     sys_wr_req, sys_addr, got.wr, got.addr);
          end
        end
      end
      prev_wr = sys_wr_req;
      prev_rd = sys_rd_req;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic expect_req(input logic wr, input logic [21:0] addr);
    exp_t e;
    e.wr   = wr;
    e.addr = addr;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int target, input int limit, input string name);
    int n = 0;
    while (done_cnt < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic wait_acks(input int target, input logic wr, input int limit);
    int n = 0;
    while ((wr ? wr_ack_cnt : rd_ack_cnt) < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("ack_timeout", 32'((wr ? wr_ack_cnt : rd_ack_cnt) >= target), 32'd1);
  endtask

  initial begin
    int d0;
    rst_n           = 1'b0;
    sdram_init_done = 1'b0;
    wr_bank = 2'd0;
    rd_bank = 2'd1;
    wr_load = 1'b0;
    rd_load = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wr_req", 32'(sys_wr_req), 0);
    chk("rst_rd_req", 32'(sys_rd_req), 0);
    chk("rst_addr", 32'(sys_addr), 0);
    chk("rst_wdone", 32'(frame_write_done), 0);
    chk("rst_rdone", 32'(frame_read_done), 0);
    rst_n = 1'b1;

    // Both paths eligible but init not done: nothing may issue.
    wr_limit = 2;
    rd_limit = 2;
    rd_level = 11'd0;
    repeat (8) @(negedge clk);
    chk("init_hold", 32'({sys_wr_req, sys_rd_req}), 0);

    // Round-robin ties starting from last_grant = read.
    expect_req(1'b1, 22'h000000);
    expect_req(1'b0, 22'h100000);
    expect_req(1'b1, 22'h000100);
    expect_req(1'b0, 22'h100100);
    sdram_init_done = 1'b1;
    wait_done(4, 200, "tie_timeout");

    // Long burst, then the next write must come from the advanced address.
    done_dly = 260;
    expect_req(1'b1, 22'h000200);
    expect_req(1'b1, 22'h000300);
    wr_limit = wr_ack_cnt + 2;
    wait_done(done_cnt + 2, 1000, "long_timeout");

    // Full frame on bank 2 from address 0.
    ack_dly  = 1;
    done_dly = 2;
    wr_bank  = 2'd2;
    wr_load  = 1'b1;
    @(negedge clk);
    wr_load = 1'b0;
    for (int i = 0; i < 1200; i++) expect_req(1'b1, {2'd2, 20'(i * 256)});
    d0 = done_cnt;
    wr_limit = wr_ack_cnt + 1200;
    wait_done(d0 + 1200, 20000, "frame_timeout");
    chk("frame_wdone_set", 32'(frame_write_done), 1);
    wr_limit = wr_ack_cnt + 1;
    repeat (20) @(negedge clk);
    chk("frame_wdone_hold", 32'(frame_write_done), 1);
    chk("frame_no_write", 32'(sys_wr_req), 0);
    expect_req(1'b1, 22'h200000);
    wr_load = 1'b1;
    @(negedge clk);
    wr_load = 1'b0;
    chk("frame_wdone_clr", 32'(frame_write_done), 0);
    wait_done(done_cnt + 1, 100, "reload_timeout");

    // Read path: restart, five bursts, then a load during the sixth burst's wait.
    rd_bank = 2'd0;
    rd_load = 1'b1;
    @(negedge clk);
    rd_load = 1'b0;
    for (int i = 0; i < 5; i++) expect_req(1'b0, {2'd0, 20'(i * 256)});
    rd_limit = rd_ack_cnt + 5;
    wait_done(done_cnt + 5, 200, "rd5_timeout");
    done_dly = 10;
    expect_req(1'b0, 22'h000500);
    d0 = done_cnt;
    rd_limit = rd_ack_cnt + 1;
    wait_acks(rd_limit, 1'b0, 50);
    repeat (2) @(negedge clk);
    rd_load = 1'b1;
    @(negedge clk);
    rd_load = 1'b0;
    wait_done(d0 + 1, 50, "rdload_timeout");
    chk("rdload_flag", 32'(frame_read_done), 0);
    done_dly = 3;
    expect_req(1'b0, 22'h000000);
    rd_limit = rd_ack_cnt + 1;
    wait_done(done_cnt + 1, 50, "rd0_timeout");

    // Read FIFO threshold: 769 blocks, 768 permits.
    rd_level = 11'd769;
    rd_limit = rd_ack_cnt + 1;
    repeat (10) @(negedge clk);
    chk("rfifo_769", 32'(sys_rd_req), 0);
    expect_req(1'b0, 22'h000100);
    rd_level = 11'd768;
    wait_done(done_cnt + 1, 50, "rfifo_768_timeout");

    // Reset during WR_WAIT.
    wr_bank  = 2'd0;
    ack_dly  = 2;
    done_dly = 50;
    expect_req(1'b1, 22'h000100);
    wr_limit = wr_ack_cnt + 1;
    wait_acks(wr_limit, 1'b1, 50);
    repeat (3) @(negedge clk);
    abort_expected = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_req", 32'(sys_wr_req), 0);
    chk("mid_rst_rd_req", 32'(sys_rd_req), 0);
    chk("mid_rst_addr", 32'(sys_addr), 0);
    chk("mid_rst_flags", 32'({frame_write_done, frame_read_done}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("post_rst_idle", 32'({sys_wr_req, sys_rd_req}), 0);
    abort_expected = 1'b0;
    done_dly = 3;
    expect_req(1'b1, 22'h000000);
    wr_limit = wr_ack_cnt + 1;
    wait_done(done_cnt + 1, 50, "post_rst_timeout");

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
